// File: rtl/tlp_retry_store.sv
// Data-link TX store: numbers each TLP, copies it into a retry-buffer slot in BRAM
// and forwards every beat downstream through a one-cycle register slice.
module tlp_retry_store #(
    parameter int DATA_WIDTH       = 32,
    parameter int KEEP_WIDTH       = DATA_WIDTH / 8,
    parameter int USER_WIDTH       = 1,
    parameter int MAX_PAYLOAD_SIZE = 0,
    parameter int RAM_DATA_WIDTH   = 32,
    parameter int RAM_ADDR_WIDTH   = 10,
    parameter int RETRY_TLP_SIZE   = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata_i,
    input  logic [KEEP_WIDTH-1:0]     s_axis_tkeep_i,
    input  logic                      s_axis_tvalid_i,
    input  logic                      s_axis_tlast_i,
    input  logic [USER_WIDTH-1:0]     s_axis_tuser_i,
    output logic                      s_axis_tready_o,
    input  logic                      retry_available_i,
    input  logic [7:0]                retry_index_i,
    output logic [11:0]               tx_seq_num_o,
    output logic                      tx_valid_o,
    output logic                      bram_wr_o,
    output logic [RAM_ADDR_WIDTH-1:0] bram_addr_o,
    output logic [RAM_DATA_WIDTH-1:0] bram_data_out_o,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata_o,
    output logic [KEEP_WIDTH-1:0]     m_axis_tkeep_o,
    output logic                      m_axis_tvalid_o,
    output logic                      m_axis_tlast_o,
    output logic [USER_WIDTH-1:0]     m_axis_tuser_o,
    input  logic                      m_axis_tready_i,
    output logic                      overflow_err_o
);

    localparam int MAX_TLP_DW = 4 + (8 << (4 + MAX_PAYLOAD_SIZE)) + 1;
    localparam int CNT_W      = 16;
    localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(MAX_TLP_DW - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_COMMIT,
        ST_DROP
    } state_t;

    state_t                    state_q, state_d;
    logic [11:0]               seq_q;
    logic [RAM_ADDR_WIDTH-1:0] base_q;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      load_slot;
    logic                      s_fire;
    logic                      drop_last;
    logic [31:0]               header;

    logic                      m_valid_q;
    logic [DATA_WIDTH-1:0]     m_data_q;
    logic [KEEP_WIDTH-1:0]     m_keep_q;
    logic                      m_last_q;
    logic [USER_WIDTH-1:0]     m_user_q;

    // Slot count is owned by retry_management; the incoming index is taken as given.
    logic unused_cfg;
    assign unused_cfg = |RETRY_TLP_SIZE;

    function automatic logic [RAM_ADDR_WIDTH-1:0] slot_base(input logic [7:0] idx);
        logic [31:0] prod;
        prod = 32'(idx) * 32'(MAX_TLP_DW);
        return prod[RAM_ADDR_WIDTH-1:0];
    endfunction

    assign header = {4'b0000, seq_q, cnt_q};

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        load_slot       = 1'b0;
        s_fire          = 1'b0;
        drop_last       = 1'b0;
        s_axis_tready_o = 1'b0;
        bram_wr_o       = 1'b0;
        bram_addr_o     = '0;
        bram_data_out_o = '0;
        tx_valid_o      = 1'b0;
        tx_seq_num_o    = '0;
        overflow_err_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s_axis_tvalid_i && retry_available_i) begin
                    load_slot = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_DATA;
                end
            end

            ST_DATA: begin
                s_axis_tready_o = !m_valid_q || m_axis_tready_i;
                s_fire          = s_axis_tvalid_i && s_axis_tready_o;
                if (s_fire) begin
                    // Beats past the slot capacity are still forwarded, just not stored.
                    if (cnt_q < CAPACITY) begin
                        bram_wr_o       = 1'b1;
                        bram_addr_o     = base_q + RAM_ADDR_WIDTH'(cnt_q) + RAM_ADDR_WIDTH'(1);
                        bram_data_out_o = RAM_DATA_WIDTH'(s_axis_tdata_i);
                    end
                    if (cnt_q <= CAPACITY) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (s_axis_tlast_i) begin
                        if (cnt_q >= CAPACITY) begin
                            drop_last = 1'b1;
                            state_d   = ST_DROP;
                        end else begin
                            state_d = ST_COMMIT;
                        end
                    end
                end
            end

            ST_COMMIT: begin
                bram_wr_o       = 1'b1;
                bram_addr_o     = base_q;
                bram_data_out_o = RAM_DATA_WIDTH'(header);
                tx_valid_o      = 1'b1;
                tx_seq_num_o    = seq_q;
                state_d         = ST_IDLE;
            end

            ST_DROP: begin
                overflow_err_o = 1'b1;
                state_d        = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            seq_q     <= '0;
            base_q    <= '0;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
            m_user_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_slot) begin
                base_q <= slot_base(retry_index_i);
            end
            if (state_q == ST_COMMIT) begin
                seq_q <= seq_q + 12'd1;
            end
            if (s_fire) begin
                m_valid_q <= 1'b1;
                m_data_q  <= s_axis_tdata_i;
                m_keep_q  <= s_axis_tkeep_i;
                m_last_q  <= s_axis_tlast_i;
                m_user_q  <= s_axis_tuser_i | USER_WIDTH'(drop_last);
            end else if (m_axis_tready_i) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid_o = m_valid_q;
    assign m_axis_tdata_o  = m_data_q;
    assign m_axis_tkeep_o  = m_keep_q;
    assign m_axis_tlast_o  = m_last_q;
    assign m_axis_tuser_o  = m_user_q;

endmodule

// File: tb/tb_tlp_retry_store.sv
// Directed bench for tlp_retry_store: a queue-based model predicts BRAM writes, forwarded
// beats, commits and overflow pulses per TLP; one monitor compares them every cycle.
module tb_tlp_retry_store;

    localparam int DW      = 32;
    localparam int KW      = 4;
    localparam int UW      = 1;
    localparam int AW      = 10;
    localparam int RDW     = 32;
    localparam int SLOT_DW = 133;
    localparam int CAP     = SLOT_DW - 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic [UW-1:0] s_tuser = '0;
    logic          s_tready;
    logic          retry_avail = 1'b1;
    logic [7:0]    retry_idx = '0;
    logic [11:0]   tx_seq;
    logic          tx_valid;
    logic          bram_wr;
    logic [AW-1:0] bram_addr;
    logic [RDW-1:0] bram_data;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tvalid;
    logic          m_tlast;
    logic [UW-1:0] m_tuser;
    logic          m_tready = 1'b1;
    logic          overflow;

    tlp_retry_store dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .s_axis_tdata_i    (s_tdata),
        .s_axis_tkeep_i    (s_tkeep),
        .s_axis_tvalid_i   (s_tvalid),
        .s_axis_tlast_i    (s_tlast),
        .s_axis_tuser_i    (s_tuser),
        .s_axis_tready_o   (s_tready),
        .retry_available_i (retry_avail),
        .retry_index_i     (retry_idx),
        .tx_seq_num_o      (tx_seq),
        .tx_valid_o        (tx_valid),
        .bram_wr_o         (bram_wr),
        .bram_addr_o       (bram_addr),
        .bram_data_out_o   (bram_data),
        .m_axis_tdata_o    (m_tdata),
        .m_axis_tkeep_o    (m_tkeep),
        .m_axis_tvalid_o   (m_tvalid),
        .m_axis_tlast_o    (m_tlast),
        .m_axis_tuser_o    (m_tuser),
        .m_axis_tready_i   (m_tready),
        .overflow_err_o    (overflow)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [AW-1:0]  addr;
        logic [RDW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    wr_t         exp_wr[$];
    beat_t       exp_beat[$];
    logic [11:0] exp_seq[$];
    int          exp_ovf = 0;
    int          model_seq = 0;

    int  n_checks = 0;
    int  n_fail = 0;
    bit  sb_en = 1'b0;
    bit  toggle_en = 1'b0;
    int  cyc = 0;
    bit  watch_acc = 1'b0;
    int  acc_edge = 0;
    int  n_commit = 0;
    int  n_ovf_seen = 0;
    logic [11:0] last_seq = '0;
    wr_t last_hdr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [KW-1:0] keep_of(input int i, input int n);
        return (i == n - 1) ? 4'h7 : 4'hF;
    endfunction

    function automatic logic [UW-1:0] user_of(input int i);
        return UW'(i % 3 == 1);
    endfunction

    // Expected behaviour of one TLP, straight from the slot layout and capacity rules.
    task automatic plan_tlp(input int idx, input int n, input logic [31:0] dbase);
        int    base;
        wr_t   w;
        beat_t b;
        base = (idx * SLOT_DW) % 1024;
        for (int i = 0; i < n; i++) begin
            if (i < CAP) begin
                w.addr = AW'((base + 1 + i) % 1024);
                w.data = dbase + 32'(i);
                exp_wr.push_back(w);
            end
            b.data = dbase + 32'(i);
            b.keep = keep_of(i, n);
            b.last = (i == n - 1);
            b.user = (i == n - 1 && n > CAP) ? UW'(1) : user_of(i);
            exp_beat.push_back(b);
        end
        if (n <= CAP) begin
            w.addr = AW'(base);
            w.data = {4'h0, 12'(model_seq), 16'(n)};
            exp_wr.push_back(w);
            exp_seq.push_back(12'(model_seq));
            model_seq = (model_seq + 1) % 4096;
        end else begin
            exp_ovf++;
        end
    endtask

    task automatic drive_tlp(input int n, input logic [31:0] dbase);
        bit acc;
        int budget;
        for (int i = 0; i < n; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = dbase + 32'(i);
            s_tkeep  = keep_of(i, n);
            s_tlast  = (i == n - 1);
            s_tuser  = user_of(i);
            acc      = 1'b0;
            budget   = 0;
            while (!acc) begin
                @(negedge clk_i);
                acc = s_tready;
                @(posedge clk_i);
                #1;
                budget++;
                if (!acc && budget > 200) begin
                    check("accept_timeout", 1, 0);
                    s_tvalid = 1'b0;
                    s_tlast  = 1'b0;
                    return;
                end
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send(input int idx, input int n, input logic [31:0] dbase);
        retry_idx = 8'(idx);
        plan_tlp(idx, n, dbase);
        drive_tlp(n, dbase);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((exp_beat.size() != 0 || exp_wr.size() != 0 || exp_seq.size() != 0 || exp_ovf != 0)
               && t < 400) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        check({tag, "_beats_left"}, 64'(exp_beat.size()), 0);
        check({tag, "_writes_left"}, 64'(exp_wr.size()), 0);
        check({tag, "_commits_left"}, 64'(exp_seq.size()), 0);
        check({tag, "_overflows_left"}, 64'(exp_ovf), 0);
    endtask

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    initial forever begin
        @(posedge clk_i);
        #1;
        if (toggle_en) m_tready = ~m_tready;
    end

    // Monitor: every cycle, away from the clock edge.
    initial begin
        beat_t cur;
        beat_t prev_beat;
        bit    prev_stall;
        wr_t   w;
        beat_t b;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk_i);
            cur = {m_tdata, m_tkeep, m_tlast, m_tuser};
            if (tx_valid) begin
                n_commit++;
                last_seq = tx_seq;
                last_hdr = {bram_addr, bram_data};
            end
            if (overflow) n_ovf_seen++;
            if (watch_acc && acc_edge == 0 && s_tvalid && s_tready) acc_edge = cyc + 1;

            if (sb_en) begin
                if (bram_wr) begin
                    if (exp_wr.size() == 0) begin
                        check("bram_wr_unexpected", {bram_addr, bram_data}, 0);
                    end else begin
                        w = exp_wr.pop_front();
                        check("bram_wr", {bram_addr, bram_data}, {w.addr, w.data});
                    end
                end
                if (m_tvalid && m_tready) begin
                    if (exp_beat.size() == 0) begin
                        check("m_beat_unexpected", cur, 0);
                    end else begin
                        b = exp_beat.pop_front();
                        check("m_beat", cur, b);
                    end
                end
                if (tx_valid) begin
                    if (exp_seq.size() == 0) begin
                        check("tx_valid_unexpected", {12'h0, tx_seq}, 64'h1_0000);
                    end else begin
                        check("tx_seq", tx_seq, exp_seq.pop_front());
                    end
                end
                if (overflow) begin
                    if (exp_ovf == 0) check("overflow_unexpected", 1, 0);
                    else exp_ovf--;
                end
                if (prev_stall) begin
                    check("m_hold_valid", m_tvalid, 1);
                    check("m_hold_beat", cur, prev_beat);
                end
                check("tready_vs_slice", s_tready && m_tvalid && !m_tready, 0);
                check("wr_only_accept_or_commit", bram_wr && !(s_tvalid && s_tready) && !tx_valid, 0);
                prev_stall = m_tvalid && !m_tready;
                prev_beat  = cur;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int rise_cyc;
        int commits_before;
        int ovf_before;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ctrl", {s_tready, bram_wr, tx_valid, m_tvalid, overflow}, 0);
        check("rst_data", {bram_addr, bram_data, tx_seq, m_tdata, m_tkeep, m_tlast, m_tuser}, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        sb_en = 1'b1;

        // Single 3-beat TLP into slot 0
        send(0, 3, 32'hA000_0000);
        drain("t1");
        check("t1_hdr", last_hdr, {10'd0, 32'h0000_0003});
        check("t1_seq", last_seq, 12'd0);
        check("t1_commits", n_commit, 1);

        // Back-to-back TLPs into slots 1 and 2
        send(1, 4, 32'hB100_0000);
        send(2, 2, 32'hB200_0000);
        drain("t2");
        check("t2_hdr", last_hdr, {10'd266, 32'h0002_0002});
        check("t2_seq", last_seq, 12'd2);

        // Retry buffer full: no acceptance until retry_available rises
        retry_avail = 1'b0;
        retry_idx   = 8'd1;
        plan_tlp(1, 2, 32'hC000_0000);
        s_tvalid = 1'b1;
        s_tdata  = 32'hC000_0000;
        s_tkeep  = keep_of(0, 2);
        s_tlast  = 1'b0;
        s_tuser  = user_of(0);
        repeat (20) begin
            @(negedge clk_i);
            check("full_tready", s_tready, 0);
            check("full_bram_wr", bram_wr, 0);
            @(posedge clk_i);
            #1;
        end
        watch_acc   = 1'b1;
        acc_edge    = 0;
        retry_avail = 1'b1;
        rise_cyc    = cyc;
        drive_tlp(2, 32'hC000_0000);
        watch_acc = 1'b0;
        check("full_accept_latency", acc_edge, rise_cyc + 2);
        drain("t3");

        // Downstream backpressure toggling every cycle
        toggle_en = 1'b1;
        send(0, 6, 32'hD000_0000);
        drain("t4");
        toggle_en = 1'b0;
        m_tready  = 1'b1;

        // Overflow: 134 beats into a 132-word slot, then the sequence number is reused
        commits_before = n_commit;
        ovf_before     = n_ovf_seen;
        send(0, CAP + 2, 32'hE000_0000);
        drain("t5");
        check("t5_overflow_pulses", n_ovf_seen - ovf_before, 1);
        check("t5_no_commit", n_commit - commits_before, 0);
        send(1, 1, 32'hE100_0000);
        drain("t5b");
        check("t5_seq_reused", last_seq, 12'd5);

        // Exactly full slot still commits
        send(2, CAP, 32'hE200_0000);
        drain("t5c");
        check("t5_full_hdr", last_hdr, {10'd266, 32'h0006_0084});

        // Sequence wrap 4095 -> 0
        while (model_seq != 4095) begin
            send(model_seq % 3, 1, 32'(model_seq));
        end
        drain("t6a");
        send(0, 1, 32'hF000_0000);
        drain("t6b");
        check("t6_seq_4095", last_seq, 12'd4095);
        send(1, 1, 32'hF100_0000);
        drain("t6c");
        check("t6_seq_wrap", last_seq, 12'd0);

        // Slot base wraps at the RAM address width
        send(8, 1, 32'hF800_0000);
        drain("t7");
        check("t7_hdr_wrap", last_hdr, {10'd40, 32'h0001_0001});

        // Reset in the middle of a TLP
        sb_en       = 1'b0;
        retry_idx   = 8'd0;
        s_tvalid    = 1'b1;
        s_tdata     = 32'h5555_0000;
        s_tkeep     = 4'hF;
        s_tlast     = 1'b0;
        s_tuser     = '0;
        commits_before = n_commit;
        repeat (4) begin
            @(posedge clk_i);
            #1;
        end
        rst_i    = 1'b0;
        s_tvalid = 1'b0;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("midrst_ctrl", {s_tready, bram_wr, tx_valid, m_tvalid, overflow}, 0);
        check("midrst_data", {bram_addr, bram_data, tx_seq, m_tdata, m_tkeep, m_tlast, m_tuser}, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        repeat (2) begin
            @(posedge clk_i);
            #1;
        end
        check("midrst_no_commit", n_commit - commits_before, 0);
        model_seq = 0;
        sb_en     = 1'b1;
        send(0, 2, 32'h6666_0000);
        drain("t8");
        check("t8_seq_after_reset", last_seq, 12'd0);
        check("t8_hdr", last_hdr, {10'd0, 32'h0000_0002});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
